// File: rtl/clock_route_multi_sync_ctrl_pkg.sv
// Shared types and helpers for the multi-channel clock-route enable controller.
// Provides the per-channel state encoding and the exclusive-mode arbiter primitive.
package clock_route_pkg;

  localparam int CNT_W  = 8;
  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARM   = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } ch_state_e;

  // Isolates the lowest set bit; callers zero-extend narrower vectors.
  function automatic logic [MAX_CH-1:0] onehot_lowest(input logic [MAX_CH-1:0] vec);
    return vec & (~vec + MAX_CH'(1));
  endfunction

endpackage

// File: rtl/clock_route_channel_fsm.sv
// One clock-route channel: request synchroniser, OFF/ARM/ON/DRAIN sequencer,
// settle counter and the registered gate-enable / ack outputs.
module clock_route_channel_fsm
  import clock_route_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic      clock,
  input  logic      async_resetn,
  input  logic      async_req,
  input  logic      grant,
  input  logic      test_s,
  output logic      req_s,
  output ch_state_e state,
  output logic      busy_next,
  output logic      en,
  output logic      ack
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   ack_q, ack_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_req};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (req_s && grant) begin
          state_d = ARM;
          cnt_d   = CNT_LOAD;
        end
      end
      ARM: begin
        if (!req_s) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ON: begin
        if (!req_s) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      DRAIN: begin
        // A request re-asserted here waits for OFF so the gate always settles fully.
        if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase

    if (test_s) begin
      state_d = OFF;
      cnt_d   = '0;
    end

    en_d  = test_s || (state_d == ARM) || (state_d == ON);
    ack_d = 1'b0;
    if (test_s) begin
      ack_d = req_s;
    end else begin
      case (state_d)
        ON:      ack_d = 1'b1;
        // Ack stays high through a drain only if the route had been acknowledged.
        DRAIN:   ack_d = (state_q == ON) || ack_q;
        default: ack_d = 1'b0;
      endcase
    end
  end

  assign busy_next = (state_d == ARM) || (state_d == DRAIN);

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      sync_q  <= '0;
      state_q <= OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  assign state = state_q;
  assign en    = en_q;
  assign ack   = ack_q;

endmodule

// File: rtl/clock_route_multi_sync_ctrl.sv
// N-channel clock-route enable controller with 4-phase async handshakes,
// optional one-route-at-a-time arbitration and a synchronised test override.
module clock_route_multi_sync_ctrl
  import clock_route_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int EXCLUSIVE     = 0
) (
  input  logic            clock,
  input  logic            async_resetn,
  input  logic            async_test_en,
  input  logic [N_CH-1:0] async_enable,
  output logic [N_CH-1:0] async_enable_ack,
  output logic [N_CH-1:0] control_path_enable,
  output logic            busy
);

  logic [SYNC_STAGES-1:0] test_sync_q, test_sync_d;
  logic                   test_s;
  logic                   test_hold_q, test_hold_d;
  logic                   busy_q, busy_d;

  ch_state_e              ch_state [N_CH];
  logic [N_CH-1:0]        req_s;
  logic [N_CH-1:0]        busy_next;
  logic [N_CH-1:0]        off_vec;
  logic [N_CH-1:0]        lowest;
  logic [N_CH-1:0]        grant;

  assign test_sync_d = {test_sync_q[SYNC_STAGES-2:0], async_test_en};
  assign test_s      = test_sync_q[SYNC_STAGES-1];
  assign test_hold_d = test_s;
  assign busy_d      = |busy_next;

  always_comb begin
    off_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      off_vec[i] = (ch_state[i] == OFF);
    end
    lowest = N_CH'(onehot_lowest(MAX_CH'(req_s & off_vec)));

    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (EXCLUSIVE != 0) begin
        grant[i] = lowest[i] && (&(off_vec | (N_CH'(1) << i)));
      end else begin
        grant[i] = 1'b1;
      end
      // Hold every channel in OFF for one cycle after the override lifts.
      if (test_hold_q) begin
        grant[i] = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clock_route_channel_fsm #(
      .SYNC_STAGES   (SYNC_STAGES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_ch (
      .clock        (clock),
      .async_resetn (async_resetn),
      .async_req    (async_enable[i]),
      .grant        (grant[i]),
      .test_s       (test_s),
      .req_s        (req_s[i]),
      .state        (ch_state[i]),
      .busy_next    (busy_next[i]),
      .en           (control_path_enable[i]),
      .ack          (async_enable_ack[i])
    );
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      test_sync_q <= '0;
      test_hold_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      test_sync_q <= test_sync_d;
      test_hold_q <= test_hold_d;
      busy_q      <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_clock_route_multi_sync_ctrl.sv
// Self-checking bench: per-cycle expected outputs are queued as stimulus is
// driven and compared against two instances (shared and exclusive mode).
module tb_clock_route_multi_sync_ctrl;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;
  } obs_t;

  logic       clock = 1'b0;
  logic       async_resetn;
  logic       test_a, test_b;
  logic [3:0] req_a, req_b;
  logic [3:0] en_a, ack_a, en_b, ack_b;
  logic       busy_a, busy_b;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string phase = "init";
  obs_t  q_a[$];
  obs_t  q_b[$];
  obs_t  exp_a = '0;
  obs_t  exp_b = '0;

  always #5 clock = ~clock;

  clock_route_multi_sync_ctrl #(
    .N_CH(4), .SYNC_STAGES(2), .SETTLE_CYCLES(3), .EXCLUSIVE(0)
  ) u_dut_a (
    .clock               (clock),
    .async_resetn        (async_resetn),
    .async_test_en       (test_a),
    .async_enable        (req_a),
    .async_enable_ack    (ack_a),
    .control_path_enable (en_a),
    .busy                (busy_a)
  );

  clock_route_multi_sync_ctrl #(
    .N_CH(4), .SYNC_STAGES(2), .SETTLE_CYCLES(3), .EXCLUSIVE(1)
  ) u_dut_b (
    .clock               (clock),
    .async_resetn        (async_resetn),
    .async_test_en       (test_b),
    .async_enable        (req_b),
    .async_enable_ack    (ack_b),
    .control_path_enable (en_b),
    .busy                (busy_b)
  );

  task automatic plan_a(input int n, input logic [3:0] en, input logic [3:0] ack, input logic busy);
    obs_t e;
    e.en = en; e.ack = ack; e.busy = busy;
    repeat (n) q_a.push_back(e);
  endtask

  task automatic plan_b(input int n, input logic [3:0] en, input logic [3:0] ack, input logic busy);
    obs_t e;
    e.en = en; e.ack = ack; e.busy = busy;
    repeat (n) q_b.push_back(e);
  endtask

  // Advance n clocks; an empty queue means the last expectation still holds.
  task automatic run(input int n);
    obs_t got_a, got_b;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (q_a.size() > 0) exp_a = q_a.pop_front();
      if (q_b.size() > 0) exp_b = q_b.pop_front();
      got_a = {en_a, ack_a, busy_a};
      got_b = {en_b, ack_b, busy_b};
      total++;
      if (got_a !== exp_a) begin
        bad++;
        $display("FAIL %s dut_a cyc=%0d got en=%b ack=%b busy=%b want en=%b ack=%b busy=%b",
                 phase, cyc, got_a.en, got_a.ack, got_a.busy, exp_a.en, exp_a.ack, exp_a.busy);
      end
      total++;
      if (got_b !== exp_b) begin
        bad++;
        $display("FAIL %s dut_b cyc=%0d got en=%b ack=%b busy=%b want en=%b ack=%b busy=%b",
                 phase, cyc, got_b.en, got_b.ack, got_b.busy, exp_b.en, exp_b.ack, exp_b.busy);
      end
      total++;
      if ($countones(en_b) > 1) begin
        bad++;
        $display("FAIL %s exclusive cyc=%0d got en=%b want at most one bit set", phase, cyc, en_b);
      end
    end
  endtask

  task automatic test_reset();
    phase = "reset";
    async_resetn = 1'b0;
    test_a = 1'b0; test_b = 1'b0;
    req_a = '0; req_b = '0;
    #3;
    total++;
    if ({en_a, ack_a, busy_a} !== 9'b0) begin
      bad++;
      $display("FAIL reset_a got en=%b ack=%b busy=%b want all 0", en_a, ack_a, busy_a);
    end
    total++;
    if ({en_b, ack_b, busy_b} !== 9'b0) begin
      bad++;
      $display("FAIL reset_b got en=%b ack=%b busy=%b want all 0", en_b, ack_b, busy_b);
    end
    repeat (2) @(posedge clock);
    #1;
    async_resetn = 1'b1;
    run(3);
  endtask

  task automatic test_single();
    phase = "single_rise";
    req_a[1] = 1'b1;
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0010, 4'b0000, 1'b1);
    plan_a(3, 4'b0010, 4'b0010, 1'b0);
    run(8);
    phase = "single_fall";
    req_a[1] = 1'b0;
    plan_a(2, 4'b0010, 4'b0010, 1'b0);
    plan_a(3, 4'b0000, 4'b0010, 1'b1);
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  task automatic test_abort();
    phase = "abort_arm";
    req_a[0] = 1'b1;
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(1, 4'b0001, 4'b0000, 1'b1);
    run(3);
    phase = "abort_drain";
    req_a[0] = 1'b0;
    plan_a(2, 4'b0001, 4'b0000, 1'b1);
    plan_a(3, 4'b0000, 4'b0000, 1'b1);
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  task automatic test_rerequest_drain();
    phase = "rereq_on";
    req_a[0] = 1'b1;
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0001, 4'b0000, 1'b1);
    plan_a(2, 4'b0001, 4'b0001, 1'b0);
    run(7);
    phase = "rereq_drop";
    req_a[0] = 1'b0;
    plan_a(2, 4'b0001, 4'b0001, 1'b0);
    plan_a(1, 4'b0000, 4'b0001, 1'b1);
    run(3);
    phase = "rereq_again";
    req_a[0] = 1'b1;
    plan_a(2, 4'b0000, 4'b0001, 1'b1);
    plan_a(1, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0001, 4'b0000, 1'b1);
    plan_a(2, 4'b0001, 4'b0001, 1'b0);
    run(8);
    phase = "rereq_clean";
    req_a[0] = 1'b0;
    plan_a(2, 4'b0001, 4'b0001, 1'b0);
    plan_a(3, 4'b0000, 4'b0001, 1'b1);
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  task automatic test_exclusive();
    phase = "excl_both";
    req_b = 4'b1100;
    plan_b(2, 4'b0000, 4'b0000, 1'b0);
    plan_b(3, 4'b0100, 4'b0000, 1'b1);
    plan_b(2, 4'b0100, 4'b0100, 1'b0);
    run(7);
    phase = "excl_handover";
    req_b = 4'b1000;
    plan_b(2, 4'b0100, 4'b0100, 1'b0);
    plan_b(3, 4'b0000, 4'b0100, 1'b1);
    plan_b(1, 4'b0000, 4'b0000, 1'b0);
    plan_b(3, 4'b1000, 4'b0000, 1'b1);
    plan_b(2, 4'b1000, 4'b1000, 1'b0);
    run(11);
    phase = "excl_clean";
    req_b = 4'b0000;
    plan_b(2, 4'b1000, 4'b1000, 1'b0);
    plan_b(3, 4'b0000, 4'b1000, 1'b1);
    plan_b(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  task automatic test_override();
    phase = "ovr_on";
    req_a = 4'b0101;
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0101, 4'b0000, 1'b1);
    plan_a(2, 4'b0101, 4'b0101, 1'b0);
    run(7);
    phase = "ovr_set";
    test_a = 1'b1;
    plan_a(2, 4'b0101, 4'b0101, 1'b0);
    plan_a(3, 4'b1111, 4'b0101, 1'b0);
    run(5);
    phase = "ovr_clear";
    test_a = 1'b0;
    plan_a(2, 4'b1111, 4'b0101, 1'b0);
    plan_a(1, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0101, 4'b0000, 1'b1);
    plan_a(2, 4'b0101, 4'b0101, 1'b0);
    run(8);
    phase = "ovr_clean";
    req_a = 4'b0000;
    plan_a(2, 4'b0101, 4'b0101, 1'b0);
    plan_a(3, 4'b0000, 4'b0101, 1'b1);
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  task automatic test_async_reset();
    phase = "areset_on";
    req_a[1] = 1'b1;
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0010, 4'b0000, 1'b1);
    plan_a(2, 4'b0010, 4'b0010, 1'b0);
    run(7);
    #2;
    async_resetn = 1'b0;
    #1;
    total++;
    if ({en_a, ack_a, busy_a} !== 9'b0) begin
      bad++;
      $display("FAIL areset_immediate got en=%b ack=%b busy=%b want all 0", en_a, ack_a, busy_a);
    end
    exp_a = '0;
    exp_b = '0;
    phase = "areset_held";
    run(2);
    async_resetn = 1'b1;
    phase = "areset_rearm";
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    plan_a(3, 4'b0010, 4'b0000, 1'b1);
    plan_a(2, 4'b0010, 4'b0010, 1'b0);
    run(7);
    phase = "areset_clean";
    req_a[1] = 1'b0;
    plan_a(2, 4'b0010, 4'b0010, 1'b0);
    plan_a(3, 4'b0000, 4'b0010, 1'b1);
    plan_a(2, 4'b0000, 4'b0000, 1'b0);
    run(7);
  endtask

  initial begin
    test_reset();
    test_single();
    test_abort();
    test_rerequest_drain();
    test_exclusive();
    test_override();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached in phase %s", phase);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_route_multi_sync_ctrl.md
Name: clock_route_multi_sync_ctrl

Overview:
- Parametrised successor to the single-channel clock-route control sync.
- Manages N_CH clock-route gate enables, each driven by an asynchronous 4-phase enable/ack handshake.
- Each channel has a configurable synchroniser depth and a settle window between gate toggling and the ack transition.
- Optional exclusive mode lets at most one route be active, so the block can drive a glitch-free clock-switch mux.

Parameters:
- N_CH, 4: number of clock-route channels, range 1..16.
- SYNC_STAGES, 2: flop stages on every async input, range 2..4.
- SETTLE_CYCLES, 3: clock cycles between an enable change and the ack change, range 1..255.
- EXCLUSIVE, 0: 1 means at most one channel is in ARM/ON/DRAIN at any time.

Ports:
- clock  in  1  control clock; all state is on its rising edge.
- async_resetn  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- async_test_en  in  1  asynchronous test override.
- async_enable  in  N_CH  per-channel asynchronous enable request (4-phase).
- async_enable_ack  out  N_CH  per-channel ack, registered.
- control_path_enable  out  N_CH  per-channel gate enable, registered.
- busy  out  1  any channel in ARM or DRAIN, registered.

Behaviour:
- Reset values: all flops 0, all channels in OFF, every output 0.
- Synchronisers:
  - async_enable[i] and async_test_en each pass through SYNC_STAGES flops to produce req_s[i] and test_s.
  - No logic acts on the raw async inputs.
- Per-channel FSM states: OFF, ARM, ON, DRAIN. A down-counter cnt[7:0] is loaded with SETTLE_CYCLES-1.
- OFF (en=0, ack=0):
  - req_s & grant[i] -> ARM, load cnt.
  - Otherwise stay in OFF.
- ARM (en=1, ack=0):
  - !req_s -> DRAIN, load cnt (request aborted; ack never rises).
  - Else if cnt==0 -> ON.
  - Else decrement cnt.
- ON (en=1, ack=1): !req_s -> DRAIN, load cnt.
- DRAIN (en=0, ack=1 if entered from ON, else 0):
  - When cnt==0 -> OFF, ack=0.
  - req_s reasserting during DRAIN is ignored until OFF is reached, so the drain always runs to completion.
- Registered outputs: en and ack are decoded from the next state, so they change on the same edge as the state.
- Latency from async_enable rise (ideal capture):
  - control_path_enable rises after SYNC_STAGES+1 cycles.
  - ack rises after SYNC_STAGES+1+SETTLE_CYCLES cycles.
  - Falling edges have the same latencies.
- Grant:
  - EXCLUSIVE=0: grant[i]=1 always.
  - EXCLUSIVE=1: grant[i]=1 only if every other channel is in OFF and no lower-index channel in OFF has req_s=1 (lowest index wins).
  - A granted channel's OFF->ARM transition blocks all others on the same edge.
- Test override:
  - While test_s=1: control_path_enable is all ones, async_enable_ack = req_s, all FSMs are forced to OFF with cnt=0, and busy=0.
  - On test_s fall: normal operation resumes from OFF on the next cycle. Channels with req_s=1 re-arm and their ack drops for SETTLE_CYCLES+1 cycles.
- busy = OR over channels of (state==ARM or state==DRAIN).
- Reset mid-operation: all enables and acks drop immediately (asynchronously).

Decomposition:
- Package clock_route_pkg contains:
  - enum ch_state_e {OFF, ARM, ON, DRAIN} (2 bits).
  - Constant CNT_W=8.
  - Function onehot_lowest(vec) used for exclusive arbitration.
- Sub-module clock_route_channel_fsm: one instance per channel, generated N_CH times.
  - Contains the req synchroniser, the FSM, the counter and the en/ack registers.
  - Inputs: grant, test_s. Outputs: state, en, ack.
- Top level contains the test synchroniser, the grant logic and busy.

Test Plan (N_CH=4, SYNC_STAGES=2, SETTLE_CYCLES=3):
- Single channel, EXCLUSIVE=0: raise async_enable[1] at cycle 0 -> control_path_enable[1]=1 at cycle 3, ack[1]=1 at cycle 6. Drop async_enable[1] -> enable=0 at +3, ack=0 at +6. busy=1 exactly during ARM and DRAIN.
- Abort during ARM: raise req[0], drop it 1 cycle after enable rises -> ack[0] stays 0 throughout, enable falls, channel returns to OFF after 3 DRAIN cycles.
- EXCLUSIVE=1, simultaneous req[2] and req[3] -> only ch2 is enabled. Drop req[2] -> ch3 enables 1 cycle after ch2 reaches OFF. At no cycle are two bits of control_path_enable set.
- Re-request during DRAIN: ch0 in DRAIN at cnt=2, reassert req -> DRAIN completes, OFF for 1 cycle, then ARM; ack is 0 for exactly 1 cycle between the two ON periods.
- Test override: channels 0 and 2 ON, raise async_test_en -> after 3 cycles control_path_enable=4'b1111 and ack=4'b0101. Clear it -> ch0 and ch2 re-arm, ack returns to 1 after 3+1+3 cycles.
- Async reset asserted with ch1 in ON -> enable, ack and busy are 0 immediately, without waiting for a clock edge. After release with req[1] still high -> normal ARM sequence.
